// File: rtl/ysyx_22041752_icache_rdu_pipe.sv
// I-cache read-decode stage: decodes fetch addresses, issues active-low SRAM
// way/bank read enables and stages the request for the compare stage.
module ysyx_22041752_icache_rdu_pipe #(
   parameter int ADDR_W   = 64,
   parameter int OFFSET_W = 4,
   parameter int INDEX_W  = 7,
   parameter int WAYS     = 2,
   parameter int BANKS    = 2,
   parameter int CNT_W    = 16,
   localparam int BANK_W  = $clog2(BANKS),
   localparam int SET_W   = INDEX_W - BANK_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic                    flush,
   input  logic [BANKS-1:0]        refill_busy,
   input  logic                    cs_allowin,
   output logic                    cs_valid,
   output logic [ADDR_W-1:0]       cs_addr,
   output logic [WAYS*BANKS-1:0]   cs_en,
   output logic [WAYS*BANKS-1:0]   sram_cen_n,
   output logic [SET_W-1:0]        sram_addr,
   output logic [CNT_W-1:0]        conflict_cnt
);

   localparam int BANK_WI = (BANK_W > 0) ? BANK_W : 1;

   logic [INDEX_W-1:0]    index_s;
   logic [BANK_WI-1:0]    bank_s;
   logic                  conflict_s;
   logic                  fire_s;

   logic                  s_valid_q, s_valid_d;
   logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
   logic [WAYS*BANKS-1:0] s_en_q, s_en_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign index_s   = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign sram_addr = index_s[SET_W-1:0];

   // A single-bank configuration has no bank field in the index.
   if (BANK_W > 0) begin : g_bank
      assign bank_s = index_s[INDEX_W-1 -: BANK_WI];
   end else begin : g_nobank
      assign bank_s = 1'b0;
   end

   assign conflict_s = refill_busy[bank_s];
   assign req_ready  = !rst && !flush && !conflict_s && (!s_valid_q || cs_allowin);
   assign fire_s     = req_valid && req_ready;

   // Read enables: only the ways of the decoded bank, and only on a fire, so a
   // stalled request keeps its SRAM data on the outputs.
   always_comb begin
      sram_cen_n = '1;
      for (int b = 0; b < BANKS; b++) begin
         for (int w = 0; w < WAYS; w++) begin
            if (fire_s && (bank_s == BANK_WI'(b))) begin
               sram_cen_n[b*WAYS+w] = 1'b0;
            end else begin
               sram_cen_n[b*WAYS+w] = 1'b1;
            end
         end
      end
   end

   // Stage register next state; flush outranks both fire and drain.
   always_comb begin
      s_valid_d = s_valid_q;
      s_addr_d  = s_addr_q;
      s_en_d    = s_en_q;
      if (flush) begin
         s_valid_d = 1'b0;
      end else if (fire_s) begin
         s_valid_d = 1'b1;
         s_addr_d  = req_addr;
         s_en_d    = ~sram_cen_n;
      end else if (s_valid_q && cs_allowin) begin
         s_valid_d = 1'b0;
      end else begin
         s_valid_d = s_valid_q;
      end
   end

   // Saturating count of cycles a valid request was blocked by a refill.
   always_comb begin
      cnt_d = cnt_q;
      if (req_valid && conflict_s && !flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_valid_q <= 1'b0;
         s_addr_q  <= '0;
         s_en_q    <= '0;
         cnt_q     <= '0;
      end else begin
         s_valid_q <= s_valid_d;
         s_addr_q  <= s_addr_d;
         s_en_q    <= s_en_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cs_valid     = s_valid_q;
   assign cs_addr      = s_addr_q;
   assign cs_en        = s_en_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22041752_icache_rdu_pipe.sv
// Directed bench for the I-cache read-decode stage; a second instance with a
// 2-bit conflict counter shares all inputs to observe saturation.
module tb_ysyx_22041752_icache_rdu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready, req_ready2;
   logic [63:0] req_addr;
   logic        flush;
   logic [1:0]  refill_busy;
   logic        cs_allowin;
   logic        cs_valid, cs_valid2;
   logic [63:0] cs_addr, cs_addr2;
   logic [3:0]  cs_en, cs_en2;
   logic [3:0]  sram_cen_n, sram_cen_n2;
   logic [5:0]  sram_addr, sram_addr2;
   logic [15:0] conflict_cnt;
   logic [1:0]  conflict_cnt2;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   ysyx_22041752_icache_rdu_pipe dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .flush(flush), .refill_busy(refill_busy),
      .cs_allowin(cs_allowin), .cs_valid(cs_valid), .cs_addr(cs_addr),
      .cs_en(cs_en), .sram_cen_n(sram_cen_n), .sram_addr(sram_addr),
      .conflict_cnt(conflict_cnt)
   );

   ysyx_22041752_icache_rdu_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
      .req_addr(req_addr), .flush(flush), .refill_busy(refill_busy),
      .cs_allowin(cs_allowin), .cs_valid(cs_valid2), .cs_addr(cs_addr2),
      .cs_en(cs_en2), .sram_cen_n(sram_cen_n2), .sram_addr(sram_addr2),
      .conflict_cnt(conflict_cnt2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_addr = 64'h8000_0010; flush = 1'b0;
      refill_busy = 2'b00; cs_allowin = 1'b1;
      #1;
      vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready got %b exp 0", req_ready); end
      vec_cnt++; if (sram_cen_n !== 4'hF) begin err_cnt++; $display("FAIL rst_cen got %h exp f", sram_cen_n); end
      step();
      vec_cnt++; if (cs_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b exp 0", cs_valid); end
      vec_cnt++; if (cs_addr !== 64'h0) begin err_cnt++; $display("FAIL rst_addr got %h exp 0", cs_addr); end
      vec_cnt++; if (cs_en !== 4'h0) begin err_cnt++; $display("FAIL rst_en got %h exp 0", cs_en); end
      vec_cnt++; if (conflict_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_cnt got %0d exp 0", conflict_cnt); end
      req_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      req_valid = 1'b1; req_addr = 64'h8000_0010;
      #1;
      vec_cnt++; if (sram_cen_n !== 4'b1100) begin err_cnt++; $display("FAIL basic_cen got %b exp 1100", sram_cen_n); end
      vec_cnt++; if (sram_addr !== 6'h01) begin err_cnt++; $display("FAIL basic_set got %h exp 01", sram_addr); end
      step();
      req_valid = 1'b0;
      #1;
      vec_cnt++; if (cs_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid got %b exp 1", cs_valid); end
      vec_cnt++; if (cs_addr !== 64'h8000_0010) begin err_cnt++; $display("FAIL basic_addr got %h exp 80000010", cs_addr); end
      vec_cnt++; if (cs_en !== 4'b0011) begin err_cnt++; $display("FAIL basic_en got %b exp 0011", cs_en); end
      req_valid = 1'b1; req_addr = 64'h8000_0400;
      #1;
      vec_cnt++; if (sram_cen_n !== 4'b0011) begin err_cnt++; $display("FAIL bank1_cen got %b exp 0011", sram_cen_n); end
      vec_cnt++; if (sram_addr !== 6'h00) begin err_cnt++; $display("FAIL bank1_set got %h exp 00", sram_addr); end
      step();
      vec_cnt++; if (cs_en !== 4'b1100) begin err_cnt++; $display("FAIL bank1_en got %b exp 1100", cs_en); end
      vec_cnt++; if (cs_addr !== 64'h8000_0400) begin err_cnt++; $display("FAIL bank1_addr got %h exp 80000400", cs_addr); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a;
      for (int i = 0; i < 4; i++) begin
         a = 64'h8000_0020 + 64'(i) * 64'h10;
         req_valid = 1'b1; req_addr = a;
         #1;
         vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready); end
         vec_cnt++; if (sram_cen_n !== 4'b1100) begin err_cnt++; $display("FAIL b2b_cen[%0d] got %b exp 1100", i, sram_cen_n); end
         step();
         vec_cnt++; if (cs_valid !== 1'b1 || cs_addr !== a) begin
            err_cnt++; $display("FAIL b2b_stage[%0d] got %b/%h exp 1/%h", i, cs_valid, cs_addr, a);
         end
      end
   endtask

   task automatic test_stall();
      cs_allowin = 1'b0; req_valid = 1'b1; req_addr = 64'h8000_0060;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_ready[%0d] got %b exp 0", i, req_ready); end
         vec_cnt++; if (sram_cen_n !== 4'hF) begin err_cnt++; $display("FAIL stall_cen[%0d] got %h exp f", i, sram_cen_n); end
         step();
         vec_cnt++; if (cs_valid !== 1'b1 || cs_addr !== 64'h8000_0050) begin
            err_cnt++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/80000050", i, cs_valid, cs_addr);
         end
      end
      cs_allowin = 1'b1;
      #1;
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL unstall_ready got %b exp 1", req_ready); end
      vec_cnt++; if (sram_cen_n !== 4'b1100) begin err_cnt++; $display("FAIL unstall_cen got %b exp 1100", sram_cen_n); end
      step();
      req_valid = 1'b0;
      vec_cnt++; if (cs_addr !== 64'h8000_0060) begin err_cnt++; $display("FAIL unstall_addr got %h exp 80000060", cs_addr); end
   endtask

   task automatic test_conflict();
      refill_busy = 2'b10; req_valid = 1'b1; req_addr = 64'h8000_0400;
      for (int i = 0; i < 5; i++) begin
         #1;
         vec_cnt++; if (req_ready !== 1'b0 || sram_cen_n !== 4'hF) begin
            err_cnt++; $display("FAIL conf_block[%0d] got %b/%h exp 0/f", i, req_ready, sram_cen_n);
         end
         step();
      end
      vec_cnt++; if (cs_valid !== 1'b0) begin err_cnt++; $display("FAIL conf_drain got %b exp 0", cs_valid); end
      vec_cnt++; if (conflict_cnt !== 16'd5) begin err_cnt++; $display("FAIL conf_cnt5 got %0d exp 5", conflict_cnt); end
      vec_cnt++; if (conflict_cnt2 !== 2'd3) begin err_cnt++; $display("FAIL conf_sat5 got %0d exp 3", conflict_cnt2); end
      step();
      vec_cnt++; if (conflict_cnt !== 16'd6) begin err_cnt++; $display("FAIL conf_cnt6 got %0d exp 6", conflict_cnt); end
      vec_cnt++; if (conflict_cnt2 !== 2'd3) begin err_cnt++; $display("FAIL conf_sat6 got %0d exp 3", conflict_cnt2); end
      req_addr = 64'h8000_0070;
      #1;
      vec_cnt++; if (req_ready !== 1'b1 || sram_cen_n !== 4'b1100) begin
         err_cnt++; $display("FAIL conf_other got %b/%b exp 1/1100", req_ready, sram_cen_n);
      end
      step();
      req_valid = 1'b0; refill_busy = 2'b00;
      vec_cnt++; if (cs_addr !== 64'h8000_0070) begin err_cnt++; $display("FAIL conf_other_addr got %h exp 80000070", cs_addr); end
      vec_cnt++; if (conflict_cnt !== 16'd6) begin err_cnt++; $display("FAIL conf_cnt_hold got %0d exp 6", conflict_cnt); end
   endtask

   task automatic test_flush();
      cs_allowin = 1'b0; flush = 1'b1; req_valid = 1'b1; req_addr = 64'h8000_0080;
      #1;
      vec_cnt++; if (req_ready !== 1'b0 || sram_cen_n !== 4'hF) begin
         err_cnt++; $display("FAIL flush_nofire got %b/%h exp 0/f", req_ready, sram_cen_n);
      end
      step();
      flush = 1'b0;
      #1;
      vec_cnt++; if (cs_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_drop got %b exp 0", cs_valid); end
      vec_cnt++; if (req_ready !== 1'b1 || sram_cen_n !== 4'b1100) begin
         err_cnt++; $display("FAIL flush_refire got %b/%b exp 1/1100", req_ready, sram_cen_n);
      end
      step();
      vec_cnt++; if (cs_valid !== 1'b1 || cs_addr !== 64'h8000_0080) begin
         err_cnt++; $display("FAIL flush_stage got %b/%h exp 1/80000080", cs_valid, cs_addr);
      end
   endtask

   task automatic test_reset_stall();
      rst = 1'b1;
      #1;
      vec_cnt++; if (sram_cen_n !== 4'hF || req_ready !== 1'b0) begin
         err_cnt++; $display("FAIL rst2_comb got %h/%b exp f/0", sram_cen_n, req_ready);
      end
      step();
      rst = 1'b0; req_valid = 1'b0;
      #1;
      vec_cnt++; if (cs_valid !== 1'b0 || cs_en !== 4'h0) begin
         err_cnt++; $display("FAIL rst2_stage got %b/%h exp 0/0", cs_valid, cs_en);
      end
      vec_cnt++; if (conflict_cnt !== 16'd0 || conflict_cnt2 !== 2'd0) begin
         err_cnt++; $display("FAIL rst2_cnt got %0d/%0d exp 0/0", conflict_cnt, conflict_cnt2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_conflict();
      test_flush();
      test_reset_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ysyx_22041752_icache_rdu_pipe.md
Name: ysyx_22041752_icache_rdu_pipe

Overview:
Parametrised successor to the I-cache read-decode stage. It accepts fetch requests through a valid/ready handshake and decodes each address into offset, bank and set. It issues active-low way/bank SRAM read enables plus a set address, and registers the request into a one-entry stage register that feeds the compare stage. It also adds refill-conflict stalling, flush cancellation and a saturating conflict counter.

Parameters:
ADDR_W, 64, request address width
OFFSET_W, 4, line byte-offset bits (address LSBs ignored for indexing)
INDEX_W, 7, total index bits (bank + set)
WAYS, 2, associativity
BANKS, 2, SRAM banks; power of two, 1..2^INDEX_W; BANK_W = log2(BANKS), SET_W = INDEX_W - BANK_W
CNT_W, 16, conflict counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  request accepted this cycle when high with req_valid
req_addr  in  ADDR_W  fetch address
flush  in  1  cancel held request and block acceptance this cycle
refill_busy  in  BANKS  per-bank refill write in progress
cs_allowin  in  1  compare stage can take the staged request
cs_valid  out  1  staged request valid toward compare stage
cs_addr  out  ADDR_W  staged request address
cs_en  out  WAYS*BANKS  active-high snapshot of the enables issued for the staged request; bit b*WAYS+w
sram_cen_n  out  WAYS*BANKS  active-low SRAM read enables, bit b*WAYS+w
sram_addr  out  SET_W  SRAM set address
conflict_cnt  out  CNT_W  cycles stalled by refill conflict, saturating

Behaviour:
- Decode: index = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W]; bank = index[INDEX_W-1:SET_W] (0 when BANKS=1); set = index[SET_W-1:0].
- conflict = refill_busy[bank].
- req_ready = !rst && !flush && !conflict && (!cs_valid || cs_allowin). The signal is combinational and does not depend on req_valid.
- fire = req_valid && req_ready.
- sram_cen_n: when fire, the WAYS bits of the decoded bank are 0 and all others are 1. When not fire, all bits are 1. Disabled SRAMs hold their last output, so the held request's data stays valid while stalled.
- sram_addr = set of req_addr at all times, including when not firing.
- Stage register (s_valid, s_addr, s_en), priority order:
  1. rst: s_valid=0, s_addr=0, s_en=0.
  2. flush: s_valid=0; s_addr and s_en unchanged.
  3. fire: s_valid=1, s_addr=req_addr, s_en=~sram_cen_n.
  4. cs_valid && cs_allowin: s_valid=0.
  5. Otherwise hold.
- Outputs: cs_valid=s_valid, cs_addr=s_addr, cs_en=s_en.
- Latency: SRAM read issued in cycle N; cs_valid/cs_addr presented in N+1, aligned with SRAM data.
- Back-to-back: when cs_allowin is held high, one request per cycle with zero bubbles. Draining the old entry and firing a new one in the same cycle is case 3.
- Stall: cs_valid && !cs_allowin → req_ready=0, all enables off, stage holds indefinitely.
- Conflict: a request targeting a bank with refill_busy set is not accepted. Requests to other banks are unaffected. The held stage entry still drains normally.
- conflict_cnt: reset to 0. It increments by 1 on any cycle where req_valid && conflict && !flush && !rst, and saturates at 2^CNT_W-1 with no wrap.
- Simultaneous flush and cs_allowin: flush wins and the entry is dropped. Simultaneous flush and req_valid: no fire, enables all off.
- Reset mid-stall: the next cycle has cs_valid=0 and the counter at 0. During the rst cycle, sram_cen_n is all 1s.
- Reset values: req_ready=0 during rst, cs_valid=0, cs_addr=0, cs_en=0, sram_cen_n=all 1s, conflict_cnt=0.

Test Plan:
- Defaults, req_addr=0x80000010, cs_allowin=1, no refill → same cycle: sram_cen_n=4'b1100, sram_addr=6'h01. Next cycle: cs_valid=1, cs_addr=0x80000010, cs_en=4'b0011.
- Address 0x80000400 (index 0x40, bank 1, set 0) → sram_cen_n=4'b0011, cs_en=4'b1100. Then 4 consecutive addresses with cs_allowin=1 → 4 fires in 4 cycles, no bubbles.
- Staged valid, cs_allowin=0 for 3 cycles with req_valid=1 → req_ready=0, sram_cen_n=4'hF, cs_addr stable. Raising cs_allowin → new request fires the same cycle.
- refill_busy=2'b10 with a bank-1 request for 5 cycles → no fire, conflict_cnt=5. A bank-0 request fires immediately. With CNT_W=2, 6 conflict cycles → conflict_cnt=3.
- Staged valid with cs_allowin=0, pulse flush together with req_valid → cs_valid=0 next cycle, no fire in the flush cycle, fire on the following cycle.
- Assert rst while staged and stalled → next cycle cs_valid=0, cs_en=0, conflict_cnt=0; sram_cen_n=4'hF during rst.
